div_unit: RTL and testbench

//   Multicycle signed 32-bit divider that answers the control unit's DIV request.

---
 rtl/div_unit.sv | 156 +++++++++++++++
 tb/tb_div_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multicycle signed restoring divider: quotient on lo_out, remainder on hi_out.
// Optional DIV_UNSIGNED_EN adds a div_unsigned input selecting unsigned (DIVU) operation.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
`ifdef DIV_UNSIGNED_EN
    input  logic             div_unsigned,
`endif
    input  logic             div_start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             div_done,
    output logic             div_zero,
    output logic             busy,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        FIX,
        DONE,
        ERR
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] rem, rem_nxt;
    logic [WIDTH-1:0] q, q_nxt;
    logic [WIDTH-1:0] dvs, dvs_nxt;
    logic             neg_q, neg_q_nxt;
    logic             neg_r, neg_r_nxt;
    logic             done_nxt, zero_nxt, busy_nxt;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;

    logic             uns_sel;
    logic             neg_a, neg_b;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   rem_sh;

`ifdef DIV_UNSIGNED_EN
    assign uns_sel = div_unsigned;
`else
    assign uns_sel = 1'b0;
`endif

    // Operand magnitudes; |MIN| wraps to itself and is then read as unsigned 2^(WIDTH-1).
    assign neg_a  = dividend[WIDTH-1] & ~uns_sel;
    assign neg_b  = divisor[WIDTH-1] & ~uns_sel;
    assign abs_a  = neg_a ? WIDTH'(0) - dividend : dividend;
    assign abs_b  = neg_b ? WIDTH'(0) - divisor : divisor;
    assign rem_sh = {rem, q[WIDTH-1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            rem      <= '0;
            q        <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_done <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rem      <= rem_nxt;
            q        <= q_nxt;
            dvs      <= dvs_nxt;
            neg_q    <= neg_q_nxt;
            neg_r    <= neg_r_nxt;
            div_done <= done_nxt;
            div_zero <= zero_nxt;
            busy     <= busy_nxt;
            hi_out   <= hi_nxt;
            lo_out   <= lo_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rem_nxt   = rem;
        q_nxt     = q;
        dvs_nxt   = dvs;
        neg_q_nxt = neg_q;
        neg_r_nxt = neg_r;
        done_nxt  = 1'b0;
        zero_nxt  = 1'b0;
        busy_nxt  = busy;
        hi_nxt    = hi_out;
        lo_nxt    = lo_out;

        unique case (state)
            IDLE: begin
                if (div_start) begin
                    busy_nxt = 1'b1;
                    if (divisor == '0) begin
                        zero_nxt  = 1'b1;
                        state_nxt = ERR;
                    end else begin
                        q_nxt     = abs_a;
                        dvs_nxt   = abs_b;
                        rem_nxt   = '0;
                        neg_q_nxt = neg_a ^ neg_b;
                        neg_r_nxt = neg_a;
                        cnt_nxt   = CW'(WIDTH - 1);
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                // Result of a successful subtract is below dvs, so WIDTH bits suffice.
                if (rem_sh >= {1'b0, dvs}) begin
                    rem_nxt = rem_sh[WIDTH-1:0] - dvs;
                    q_nxt   = {q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_nxt = rem_sh[WIDTH-1:0];
                    q_nxt   = {q[WIDTH-2:0], 1'b0};
                end
                cnt_nxt = cnt - CW'(1);
                if (cnt == '0) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                lo_nxt    = neg_q ? WIDTH'(0) - q : q;
                hi_nxt    = neg_r ? WIDTH'(0) - rem : rem;
                done_nxt  = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            ERR: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: arithmetic/timing reference model checked every cycle plus directed literal cases.
module tb_div_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         div_start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
`ifdef DIV_UNSIGNED_EN
    logic         div_unsigned = 1'b0;
`endif
    logic         div_done, div_zero, busy;
    logic [W-1:0] hi_out, lo_out;

    int n_checks = 0;
    int n_errors = 0;
    bit armed = 1'b0;

    div_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef DIV_UNSIGNED_EN
        .div_unsigned(div_unsigned),
`endif
        .div_start (div_start),
        .dividend  (dividend),
        .divisor   (divisor),
        .div_done  (div_done),
        .div_zero  (div_zero),
        .busy      (busy),
        .hi_out    (hi_out),
        .lo_out    (lo_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic (truncating division, remainder follows dividend)
    // and a cycle-age timeline relative to the accepting edge.
    logic [W-1:0] m_hi = '0, m_lo = '0, p_q = '0, p_r = '0;
    bit           m_busy = 0, m_done = 0, m_zero = 0, m_err = 0;
    int           age = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi = '0; m_lo = '0; m_busy = 0; m_done = 0; m_zero = 0; age = 0;
        end else if (!m_busy) begin
            if (div_start) begin
                longint sa, sb, q64, r64;
                bit u;
`ifdef DIV_UNSIGNED_EN
                u = div_unsigned;
`else
                u = 1'b0;
`endif
                m_busy = 1; age = 0;
                if (divisor == '0) begin
                    m_err = 1; m_zero = 1;
                end else begin
                    m_err = 0;
                    sa = u ? longint'(dividend) : longint'($signed(dividend));
                    sb = u ? longint'(divisor) : longint'($signed(divisor));
                    q64 = sa / sb;
                    r64 = sa % sb;
                    p_q = q64[31:0];
                    p_r = r64[31:0];
                end
            end
        end else begin
            age++;
            if (m_err && age == 1) begin
                m_zero = 0; m_busy = 0;
            end
            if (!m_err && age == W + 1) begin
                m_done = 1; m_lo = p_q; m_hi = p_r;
            end
            if (!m_err && age == W + 2) begin
                m_done = 0; m_busy = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("div_done", 32'(div_done), 32'(m_done));
            check("div_zero", 32'(div_zero), 32'(m_zero));
            check("hi_out", hi_out, m_hi);
            check("lo_out", lo_out, m_lo);
        end
    end

    // Launch one operation; optionally re-pulse div_start (100/10) at age inj_k.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int inj_k,
                           input logic [31:0] elo, input logic [31:0] ehi, input string nm);
        int k;
        @(negedge clk);
        dividend = a; divisor = b; div_start = 1'b1;
        @(negedge clk);
        div_start = 1'b0;
        k = 0;
        while (!div_done && k < 100) begin
            @(negedge clk);
            k++;
            if (k == inj_k) begin
                dividend = 32'd100; divisor = 32'd10; div_start = 1'b1;
            end else begin
                div_start = 1'b0;
            end
        end
        check({nm, " latency"}, 32'(k), 32'd33);
        check({nm, " lo"}, lo_out, elo);
        check({nm, " hi"}, hi_out, ehi);
        @(negedge clk);
        check({nm, " busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int cnt;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        armed = 1'b1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset lo", lo_out, 32'd0);
        check("reset hi", hi_out, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run_div(32'd7, 32'd2, -1, 32'h00000003, 32'h00000001, "7/2");
        run_div(32'hFFFFFFF9, 32'd2, -1, 32'hFFFFFFFD, 32'hFFFFFFFF, "-7/2");
        run_div(32'd7, 32'hFFFFFFFE, -1, 32'hFFFFFFFD, 32'h00000001, "7/-2");

        // Zero divisor: one-cycle div_zero, no div_done, results held.
        @(negedge clk);
        dividend = 32'd5; divisor = 32'd0; div_start = 1'b1;
        @(negedge clk);
        div_start = 1'b0;
        check("5/0 zero", 32'(div_zero), 32'd1);
        check("5/0 busy", 32'(busy), 32'd1);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (div_done || div_zero) cnt++;
        end
        check("5/0 no_done", 32'(cnt), 32'd0);
        check("5/0 lo_held", lo_out, 32'hFFFFFFFD);
        check("5/0 hi_held", hi_out, 32'h00000001);

        run_div(32'h80000000, 32'hFFFFFFFF, -1, 32'h80000000, 32'h00000000, "min/-1");
        run_div(32'd0, 32'd5, -1, 32'd0, 32'd0, "0/5");
        run_div(32'd7, 32'd2, 5, 32'h00000003, 32'h00000001, "ignored_start");

        // Reset in the middle of a division.
        @(negedge clk);
        dividend = 32'hFFFFFFF9; divisor = 32'd2; div_start = 1'b1;
        @(negedge clk);
        div_start = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset lo", lo_out, 32'd0);
        check("midreset hi", hi_out, 32'd0);
        check("midreset done", 32'(div_done), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        run_div(32'd9, 32'd3, -1, 32'd3, 32'd0, "9/3");

`ifdef DIV_UNSIGNED_EN
        div_unsigned = 1'b1;
        run_div(32'hFFFFFFFF, 32'd2, -1, 32'h7FFFFFFF, 32'h00000001, "divu");
        div_unsigned = 1'b0;
        run_div(32'hFFFFFFFF, 32'd2, -1, 32'h00000000, 32'hFFFFFFFF, "div_signed");
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
